// File: rtl/axi_mem_pkg.sv
// rtl/axi_mem_pkg.sv - shared state encodings and response codes for the AXI memory responder
package axi_mem_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_mem_responder_if.sv
// rtl/axi_mem_responder_if.sv - AXI4 bus bundle between the DDR initiator and the memory responder
interface axi_mem_responder_if #(
    parameter int ID_W   = 10,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_mem_ram.sv
// rtl/axi_mem_ram.sv - simple dual-port RAM, byte-enable write port, registered read-before-write read port
module axi_mem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W/8-1:0]      wstrb,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read register samples the pre-write word on a same-index collision and holds while re=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI4 slave backed by an internal RAM, one outstanding INCR burst per direction
module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int C_AXI_ID_WIDTH   = 10,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int MEM_DEPTH        = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    axi_mem_responder_if.slave  axi
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int LSB   = $clog2(C_AXI_DATA_WIDTH / 8);

    // Size/burst fields and the address bits above the RAM index carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{axi.awsize, axi.awburst, axi.arsize, axi.arburst, axi.awaddr, axi.araddr};

    w_state_t                  w_state;
    logic [C_AXI_ID_WIDTH-1:0] w_id;
    logic [IDX_W-1:0]          w_idx;
    logic [7:0]                w_len;
    logic [7:0]                w_cnt;
    logic                      w_beat;
    logic                      w_cnt_last;
    logic                      w_end;

    r_state_t                  r_state;
    logic [IDX_W-1:0]          r_idx;
    logic [7:0]                r_len;
    logic [7:0]                r_cnt;
    logic                      r_load;
    logic [IDX_W-1:0]          r_load_idx;

    assign w_beat     = axi.wvalid & axi.wready;
    assign w_cnt_last = (w_cnt == w_len);
    assign w_end      = axi.wlast | w_cnt_last;

    // Write path: address latch, data beats into RAM, then a single B response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state     <= W_IDLE;
            axi.awready <= 1'b0;
            axi.wready  <= 1'b0;
            axi.bvalid  <= 1'b0;
            axi.bid     <= '0;
            axi.bresp   <= RESP_OKAY;
            w_id        <= '0;
            w_idx       <= '0;
            w_len       <= '0;
            w_cnt       <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    axi.awready <= 1'b1;
                    if (axi.awvalid && axi.awready) begin
                        w_id        <= axi.awid;
                        w_idx       <= axi.awaddr[LSB +: IDX_W];
                        w_len       <= axi.awlen;
                        w_cnt       <= '0;
                        axi.awready <= 1'b0;
                        axi.wready  <= 1'b1;
                        w_state     <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        w_idx <= w_idx + 1'b1;
                        w_cnt <= w_cnt + 8'd1;
                        if (w_end) begin
                            // A wlast that disagrees with the beat count in either direction is an error.
                            axi.wready <= 1'b0;
                            axi.bvalid <= 1'b1;
                            axi.bid    <= w_id;
                            axi.bresp  <= (axi.wlast != w_cnt_last) ? RESP_SLVERR : RESP_OKAY;
                            w_state    <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi.bready) begin
                        axi.bvalid  <= 1'b0;
                        axi.awready <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Fetch the first word on the AR handshake, and the next word whenever a non-last beat retires.
    always_comb begin
        r_load     = 1'b0;
        r_load_idx = r_idx;
        if (r_state == R_IDLE && axi.arvalid && axi.arready) begin
            r_load     = 1'b1;
            r_load_idx = axi.araddr[LSB +: IDX_W];
        end else if (r_state == R_DATA && axi.rvalid && axi.rready && !axi.rlast) begin
            r_load = 1'b1;
        end
    end

    // Read path: rdata comes straight from the RAM read register, so it holds whenever no load occurs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= R_IDLE;
            axi.arready <= 1'b0;
            axi.rvalid  <= 1'b0;
            axi.rlast   <= 1'b0;
            axi.rid     <= '0;
            r_idx       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    axi.arready <= 1'b1;
                    if (axi.arvalid && axi.arready) begin
                        axi.rid     <= axi.arid;
                        r_len       <= axi.arlen;
                        r_cnt       <= '0;
                        axi.rlast   <= (axi.arlen == 8'd0);
                        r_idx       <= axi.araddr[LSB +: IDX_W] + 1'b1;
                        axi.arready <= 1'b0;
                        axi.rvalid  <= 1'b1;
                        r_state     <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi.rvalid && axi.rready) begin
                        if (axi.rlast) begin
                            axi.rvalid  <= 1'b0;
                            axi.rlast   <= 1'b0;
                            axi.arready <= 1'b1;
                            r_state     <= R_IDLE;
                        end else begin
                            r_cnt     <= r_cnt + 8'd1;
                            axi.rlast <= ((r_cnt + 8'd1) == r_len);
                            r_idx     <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign axi.rresp = RESP_OKAY;

    axi_mem_ram #(
        .DATA_W (C_AXI_DATA_WIDTH),
        .DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (w_beat),
        .waddr  (w_idx),
        .wstrb  (axi.wstrb),
        .wdata  (axi.wdata),
        .re     (r_load),
        .raddr  (r_load_idx),
        .rdata  (axi.rdata)
    );

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 slave (responder) backed by an internal word-addressed, byte-enable RAM; the memory-side end of the DDR AXI initiator.
- Lets the DDR initiator and its FIFO plumbing run in simulation and on FPGA without the MIG.
- Independent read and write paths.
- One outstanding burst per direction.
- INCR bursts of up to 256 beats.

Parameters:
C_AXI_ID_WIDTH, 10, width of AWID/BID/ARID/RID
C_AXI_ADDR_WIDTH, 32, byte address width
C_AXI_DATA_WIDTH, 32, data width; power of two, ≥ 32
MEM_DEPTH, 4096, RAM depth in data words; power of two

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
axi_awid  in  C_AXI_ID_WIDTH  write ID
axi_awaddr  in  C_AXI_ADDR_WIDTH  write byte address
axi_awlen  in  8  beats-1
axi_awsize  in  3  ignored (full-width beats)
axi_awburst  in  2  ignored (always INCR)
axi_awvalid  in  1  write address valid
axi_awready  out  1  write address ready
axi_wdata  in  C_AXI_DATA_WIDTH  write data
axi_wstrb  in  C_AXI_DATA_WIDTH/8  byte strobes
axi_wlast  in  1  last write beat
axi_wvalid  in  1  write data valid
axi_wready  out  1  write data ready
axi_bid  out  C_AXI_ID_WIDTH  response ID
axi_bresp  out  2  write response
axi_bvalid  out  1  response valid
axi_bready  in  1  response ready
axi_arid  in  C_AXI_ID_WIDTH  read ID
axi_araddr  in  C_AXI_ADDR_WIDTH  read byte address
axi_arlen  in  8  beats-1
axi_arsize  in  3  ignored
axi_arburst  in  2  ignored
axi_arvalid  in  1  read address valid
axi_arready  out  1  read address ready
axi_rid  out  C_AXI_ID_WIDTH  read ID
axi_rdata  out  C_AXI_DATA_WIDTH  read data
axi_rresp  out  2  read response, always 2'b00
axi_rlast  out  1  last read beat
axi_rvalid  out  1  read data valid
axi_rready  in  1  read data ready

Behaviour:
- Reset (async assert, sync deassert expected upstream):
  - All outputs 0; both FSMs return to IDLE.
  - A reset mid-burst aborts the burst: no B, no further R beats.
  - RAM contents are not reset.
- Word index:
  - Computed as (addr >> log2(DATA/8)) mod MEM_DEPTH.
  - Increments by 1 per beat and wraps at MEM_DEPTH (no error).
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On awvalid&awready, latch id, index and len; clear beat count and err; go to W_DATA next cycle.
  - W_DATA: wready=1. Each wvalid&wready writes the bytes enabled by wstrb at the current index, then index+1 and count+1.
  - The beat ends the burst when wlast=1 or count==len. Then set err if (wlast != (count==len)) and go to W_RESP.
  - Beats with count>len are never accepted; the FSM has already left W_DATA.
  - W_RESP: bvalid=1, bid=latched id, bresp = err ? 2'b10 (SLVERR) : 2'b00. Hold until bready, then W_IDLE.
  - awready is 0 outside W_IDLE.
  - Minimum turnaround: AW handshake cycle T, first W accept at T+1, B valid the cycle after the last beat.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On arvalid&arready, latch id and len, and load rdata from RAM[index]. rvalid=1 from the next cycle.
  - R_DATA: rlast=1 iff beat count==len.
  - On rvalid&rready: if rlast, drop rvalid and return to R_IDLE (arready=1 the following cycle). Otherwise load the next word into rdata and keep rvalid=1. Back-to-back beats run at 1/cycle.
  - While rvalid&!rready, rdata, rlast and rid are held stable.
- Read/write collision:
  - If an rdata load and a write beat hit the same index in the same cycle, rdata gets the old word (read-before-write).
  - Any later load sees the new word.
- Independence: the read and write FSMs may be active simultaneously; neither stalls the other.

Decomposition:
- Shared package axi_mem_pkg:
  - write-state enum (W_IDLE, W_DATA, W_RESP);
  - read-state enum (R_IDLE, R_DATA);
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
- Sub-module axi_mem_ram: simple dual-port RAM.
  - One write port with per-byte enables.
  - One registered read port with read-before-write.
  - Parameterised by data width and depth.

Test Plan:
- Single write AW addr=0x40, len=0, wdata=0xDEADBEEF, wstrb=0xF -> B OKAY with bid=awid one cycle after the W beat. A read of 0x40, len=0 -> rdata=0xDEADBEEF, rlast=1, rresp=0.
- 8-beat write at 0x100 with data 1..8, then 8-beat read with rready toggled 1,0 -> 8 beats 1..8 in order, rlast only on beat 8, rdata stable during rready=0 cycles.
- Partial strobe: word 0x11223344 at 0x0, then write 0xAABBCCDD with wstrb=0x5 -> readback 0x11BB33DD.
- Early wlast on beat 3 of a len=7 burst -> burst ends after 3 beats, bresp=2'b10, only 3 words modified. Late case: len=1 with wlast=0 on beat 2 -> SLVERR, wready=0 afterwards.
- Wrap: 4-beat write starting at word MEM_DEPTH-2 -> words MEM_DEPTH-2, MEM_DEPTH-1, 0, 1 written; readback from the same address matches.
- Reset mid-read: assert rst_n=0 during beat 3 of 8 -> rvalid, arready and bvalid go to 0 immediately. After release: arready=1, and a fresh read returns the previously written data.
